laser_line_scanner: RTL

Per-line pixel reader and laser modulator for the raster projector; the read-side counterpart to the y-axis row tracker driven by the x-axis opto strobe.
- On each polygon-mirror strobe it waits a fixed blanking delay.
- It then reads NUM_COLS pixels of the current row from the frame buffer, one pixel every PIX_CYCLES clocks.
- It drives the laser enable from that pixel data.
- Sits between the 50 MHz frame-buffer read port and the laser driver GPIO.

---
 rtl/raster_pkg.sv | 15 +
 rtl/stb_sync_edge.sv | 25 ++
 rtl/laser_line_scanner.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared raster geometry and scan-state encoding for the projector's x/y scan blocks.
package raster_pkg;

  localparam int NUM_COLS = 320;
  localparam int NUM_ROWS = 240;
  localparam int ROW_W    = 9;
  localparam int ADDR_W   = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_ACTIVE
  } scan_state_t;

endpackage

// File: rtl/stb_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// The pulse appears on the third clock edge after the asynchronous edge.
module stb_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b00;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], async_in};
      prev <= sync[1];
      rise <= sync[1] & ~prev;
    end
  end

endmodule

// File: rtl/laser_line_scanner.sv
// Per-line frame-buffer reader and laser modulator triggered by the x-axis opto strobe.
// Optional strobe watchdog (laser safety if the mirror stops) is built when STB_WATCHDOG_EN is defined.
module laser_line_scanner
  import raster_pkg::*;
#(
  parameter int NUM_COLS     = raster_pkg::NUM_COLS,
  parameter int NUM_ROWS     = raster_pkg::NUM_ROWS,
  parameter int PIX_CYCLES   = 8,
  parameter int START_DELAY  = 1000,
  parameter int PIX_W        = 8,
  parameter int LASER_THRESH = 128,
`ifdef STB_WATCHDOG_EN
  parameter int WDOG_CYCLES  = 2000000,
`endif
  parameter int ADDR_W       = raster_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x_stb_async,
  input  logic [ROW_W-1:0]  y_line,
  input  logic              y_active,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rd,
  input  logic [PIX_W-1:0]  pix_rdata,
  output logic              laser_out,
  output logic              line_start,
  output logic              line_done,
  output logic [7:0]        overrun_cnt,
  output logic              stb_lost
);

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int SUB_W = $clog2(PIX_CYCLES);
  localparam int DLY_W = $clog2(START_DELAY + 1);
  localparam logic [PIX_W-1:0] THRESH = PIX_W'(LASER_THRESH);

  scan_state_t       state;
  logic              stb_rise;
  logic              draw;
  logic              wdog_trip;
  logic              rd_d1;
  logic              done_d1;
  logic [COL_W-1:0]  col;
  logic [SUB_W-1:0]  sub;
  logic [DLY_W-1:0]  dly_cnt;
  logic [ADDR_W-1:0] base_addr;

  stb_sync_edge u_stb (
    .clk      (clk),
    .reset    (reset),
    .async_in (x_stb_async),
    .rise     (stb_rise)
  );

  assign draw = y_active && (32'(y_line) < NUM_ROWS);

`ifdef STB_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        lost;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      lost   <= 1'b0;
    end else if (stb_rise) begin
      wd_cnt <= '0;
      lost   <= 1'b0;
    end else if (wd_cnt != 32'(WDOG_CYCLES)) begin
      wd_cnt <= wd_cnt + 32'd1;
    end else begin
      lost <= 1'b1;
    end
  end

  // Holds while the count sits at the limit, pinning the FSM in IDLE until the next strobe.
  assign wdog_trip = (wd_cnt == 32'(WDOG_CYCLES)) && !stb_rise;
  assign stb_lost  = lost;
`else
  assign wdog_trip = 1'b0;
  assign stb_lost  = 1'b0;
`endif

  // Read port: a cycle with pix_rd=1 is a request for pix_addr; there is no
  // back-pressure, and pix_rdata is valid exactly one cycle later (tracked by rd_d1).
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pix_addr    <= '0;
      pix_rd      <= 1'b0;
      laser_out   <= 1'b0;
      line_start  <= 1'b0;
      line_done   <= 1'b0;
      overrun_cnt <= '0;
      rd_d1       <= 1'b0;
      done_d1     <= 1'b0;
      col         <= '0;
      sub         <= '0;
      dly_cnt     <= '0;
      base_addr   <= '0;
    end else begin
      pix_rd     <= 1'b0;
      line_start <= 1'b0;
      line_done  <= 1'b0;
      rd_d1      <= pix_rd;
      done_d1    <= line_done;

      if (rd_d1)
        laser_out <= (pix_rdata >= THRESH);
      else if (done_d1)
        laser_out <= 1'b0;

      if (wdog_trip) begin
        state     <= S_IDLE;
        laser_out <= 1'b0;
        rd_d1     <= 1'b0;
        done_d1   <= 1'b0;
      end else if (stb_rise) begin
        if (state != S_IDLE) begin
          // Overrun: drop the line and any read data still in flight.
          laser_out <= 1'b0;
          rd_d1     <= 1'b0;
          done_d1   <= 1'b0;
          if (overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
        end
        if (draw) begin
          base_addr <= ADDR_W'(y_line) * ADDR_W'(NUM_COLS);
          dly_cnt   <= '0;
          state     <= S_DELAY;
        end else begin
          state <= S_IDLE;
        end
      end else begin
        case (state)
          S_DELAY: begin
            if (dly_cnt == DLY_W'(START_DELAY - 1)) begin
              state      <= S_ACTIVE;
              col        <= '0;
              sub        <= '0;
              pix_rd     <= 1'b1;
              pix_addr   <= base_addr;
              line_start <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt + DLY_W'(1);
            end
          end
          S_ACTIVE: begin
            if (sub == SUB_W'(PIX_CYCLES - 1)) begin
              if (col == COL_W'(NUM_COLS - 1)) begin
                state     <= S_IDLE;
                line_done <= 1'b1;
              end else begin
                col      <= col + COL_W'(1);
                sub      <= '0;
                pix_rd   <= 1'b1;
                pix_addr <= base_addr + ADDR_W'(col) + ADDR_W'(1);
              end
            end else begin
              sub <= sub + SUB_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
